// File: rtl/vector_accumulate_unit_if.sv
// Stream bus between the upstream reduce stage, the accumulator and its consumer.
interface vector_accumulate_unit_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                             acc_en;
  logic                             valid_in;
  logic                             eof_in;
  logic [N-1:0][DATA_WIDTH-1:0]     vector_in;
  logic                             valid_out;
  logic                             eof_out;
  logic [N-1:0][DATA_WIDTH-1:0]     vector_out;
  logic [CNT_WIDTH-1:0]             count_out;

  modport master (
    output acc_en, valid_in, eof_in, vector_in,
    input  valid_out, eof_out, vector_out, count_out
  );

  modport slave (
    input  acc_en, valid_in, eof_in, vector_in,
    output valid_out, eof_out, vector_out, count_out
  );
endinterface

// File: rtl/vector_accumulate_unit.sv
// Per-frame vector accumulator: sums lanes of incoming vectors until eof, or
// passes vectors straight through when accumulation is disabled.

module vau_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  add,
  input  logic                  clr,
  input  logic                  emit,
  input  logic                  use_sum,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] sum;

  // Modulo 2^DATA_WIDTH; carry out is dropped on purpose.
  assign sum = acc + din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      dout <= '0;
    end else begin
      if (clr)      acc <= '0;
      else if (add) acc <= sum;
      if (emit)     dout <= use_sum ? sum : din;
    end
  end
endmodule

module vector_accumulate_unit #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vector_accumulate_unit_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_cur, cnt_inc;
  logic                 add, clr, emit, use_sum;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 valid_q, eof_q;
  logic [CNT_WIDTH-1:0] count_q;

  // cnt is only meaningful while ACCUM; in IDLE the frame is empty.
  assign cnt_cur = (state == ACCUM) ? cnt : '0;
  assign cnt_inc = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    add       = 1'b0;
    clr       = 1'b0;
    emit      = 1'b0;
    use_sum   = 1'b0;
    count_nxt = CNT_ONE;
    if (!bus.acc_en) begin
      // Pass-through, and any partial frame is dropped on this edge.
      state_nxt = IDLE;
      cnt_nxt   = '0;
      clr       = 1'b1;
      emit      = bus.valid_in;
    end else if (bus.valid_in) begin
      use_sum   = 1'b1;
      count_nxt = cnt_inc;
      if (bus.eof_in) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        clr       = 1'b1;
        emit      = 1'b1;
      end else begin
        state_nxt = ACCUM;
        cnt_nxt   = cnt_inc;
        add       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        eof_q   <= bus.eof_in;
        count_q <= count_nxt;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      vau_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (bus.vector_in[g]),
        .add     (add),
        .clr     (clr),
        .emit    (emit),
        .use_sum (use_sum),
        .dout    (bus.vector_out[g])
      );
    end
  endgenerate

  assign bus.valid_out = valid_q;
  assign bus.eof_out   = eof_q;
  assign bus.count_out = count_q;
endmodule

// File: tb/tb_vector_accumulate_unit.sv
// Scoreboard bench for vector_accumulate_unit: expected outputs are queued with
// their due cycle as stimulus is driven and checked when the DUT emits.
module tb_vector_accumulate_unit;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t           v;
    logic [CW-1:0]  c;
    logic           e;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t sbq[$];
  vec_t m_acc;
  int   m_cnt;
  vec_t last_v;
  logic [CW-1:0] last_c;
  logic last_e;

  vector_accumulate_unit_if #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  vector_accumulate_unit #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every pulse and checks hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_v = '0; last_c = '0; last_e = 1'b0;
    end else if (bus.valid_out) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out cyc=%0d got v=%h c=%0d e=%b, none expected",
                 cyc, bus.vector_out, bus.count_out, bus.eof_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.vector_out !== e.v || bus.count_out !== e.c ||
            bus.eof_out !== e.e || cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL out_match got v=%h c=%0d e=%b cyc=%0d, want v=%h c=%0d e=%b cyc=%0d",
                   bus.vector_out, bus.count_out, bus.eof_out, cyc, e.v, e.c, e.e, e.cyc);
        end
      end
      last_v = bus.vector_out; last_c = bus.count_out; last_e = bus.eof_out;
    end else begin
      n_checks++;
      if (bus.vector_out !== last_v || bus.count_out !== last_c || bus.eof_out !== last_e) begin
        n_fail++;
        $display("FAIL hold got v=%h c=%0d e=%b, want v=%h c=%0d e=%b",
                 bus.vector_out, bus.count_out, bus.eof_out, last_v, last_c, last_e);
      end
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        n_fail++;
        $display("FAIL missing_out cyc=%0d got valid_out=0, want v=%h c=%0d",
                 cyc, sbq[0].v, sbq[0].c);
        void'(sbq.pop_front());
      end
    end
  end

  // Drive one cycle of stimulus and record what the block owes us for it.
  task automatic step(input logic en, input logic v, input logic e, input vec_t d);
    exp_t x;
    bus.acc_en = en; bus.valid_in = v; bus.eof_in = e; bus.vector_in = d;
    if (v && (!en || e)) begin
      for (int i = 0; i < N; i++) x.v[i] = en ? m_acc[i] + d[i] : d[i];
      x.c   = en ? CW'((m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1) : CW'(1);
      x.e   = e;
      x.cyc = cyc + 1;
      sbq.push_back(x);
    end
    if (!en || (v && e)) begin
      m_acc = '0; m_cnt = 0;
    end else if (v) begin
      for (int i = 0; i < N; i++) m_acc[i] = m_acc[i] + d[i];
      m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic drain(input string name);
    idle(2);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got %0d pending outputs, want 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  function automatic vec_t lane0(input logic [DW-1:0] x);
    vec_t d;
    d = '0;
    d[0] = x;
    return d;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    m_acc = '0; m_cnt = 0;
    #3;
    n_checks++;
    if (bus.valid_out !== 1'b0 || bus.eof_out !== 1'b0 || bus.vector_out !== '0 || bus.count_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%b eof=%b v=%h c=%0d, want all 0",
               bus.valid_out, bus.eof_out, bus.vector_out, bus.count_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.acc_en = 1'b1; bus.valid_in = 1'b1; bus.eof_in = 1'b1; bus.vector_in = lane0(32'hDEAD);
    m_acc = '0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();
    // First edge after release must take the sample.
    step(1'b1, 1'b1, 1'b1, lane0(32'd6));
    n_checks++;
    if (bus.valid_out !== 1'b1 || bus.vector_out[0] !== 32'd6 || bus.count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL first_after_reset got valid=%b lane0=%0d c=%0d, want 1 6 1",
               bus.valid_out, bus.vector_out[0], bus.count_out);
    end
    drain("reset");
  endtask

  task automatic test_pass_through();
    step(1'b0, 1'b1, 1'b0, lane0(32'd5));
    n_checks++;
    if (bus.valid_out !== 1'b1 || bus.vector_out !== lane0(32'd5) || bus.count_out !== 4'd1 || bus.eof_out !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_through got valid=%b v=%h c=%0d e=%b, want 1 lane0=5 1 0",
               bus.valid_out, bus.vector_out, bus.count_out, bus.eof_out);
    end
    step(1'b0, 1'b1, 1'b1, lane0(32'd11));
    n_checks++;
    if (bus.eof_out !== 1'b1 || bus.vector_out[0] !== 32'd11) begin
      n_fail++;
      $display("FAIL pass_through_eof got e=%b lane0=%0d, want 1 11", bus.eof_out, bus.vector_out[0]);
    end
    drain("pass_through");
  endtask

  task automatic test_frame_sum();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, k == 4, lane0(k));
      if (k < 4) begin
        n_checks++;
        if (bus.valid_out !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_sum_early got valid_out=%b after sample %0d, want 0", bus.valid_out, k);
        end
      end
    end
    n_checks++;
    if (bus.valid_out !== 1'b1 || bus.vector_out[0] !== 32'd10 || bus.count_out !== 4'd4 || bus.eof_out !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_sum got valid=%b lane0=%0d c=%0d e=%b, want 1 10 4 1",
               bus.valid_out, bus.vector_out[0], bus.count_out, bus.eof_out);
    end
    drain("frame_sum");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 1'b1, lane0(32'd7));
    n_checks++;
    if (bus.valid_out !== 1'b1 || bus.vector_out[0] !== 32'd7 || bus.count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_first got valid=%b lane0=%0d c=%0d, want 1 7 1",
               bus.valid_out, bus.vector_out[0], bus.count_out);
    end
    step(1'b1, 1'b1, 1'b1, lane0(32'd3));
    n_checks++;
    if (bus.valid_out !== 1'b1 || bus.vector_out[0] !== 32'd3 || bus.count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_second got valid=%b lane0=%0d c=%0d, want 1 3 1",
               bus.valid_out, bus.vector_out[0], bus.count_out);
    end
    drain("back_to_back");
  endtask

  task automatic test_wrap();
    vec_t d;
    step(1'b1, 1'b1, 1'b0, lane0(32'hFFFF_FFFF));
    d = lane0(32'd2);
    d[1] = 32'd9;
    step(1'b1, 1'b1, 1'b1, d);
    n_checks++;
    if (bus.vector_out[0] !== 32'h0000_0001 || bus.vector_out[1] !== 32'd9 || bus.count_out !== 4'd2) begin
      n_fail++;
      $display("FAIL wrap got lane0=%h lane1=%0d c=%0d, want 00000001 9 2",
               bus.vector_out[0], bus.vector_out[1], bus.count_out);
    end
    drain("wrap");
  endtask

  task automatic test_abort();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, lane0(32'd100));
    pulse_reset();
    step(1'b1, 1'b1, 1'b1, lane0(32'd9));
    n_checks++;
    if (bus.vector_out[0] !== 32'd9 || bus.count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL abort_reset got lane0=%0d c=%0d, want 9 1", bus.vector_out[0], bus.count_out);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, lane0(32'd50));
    // acc_en drop with a live sample: partial frame dropped, sample passed through.
    step(1'b0, 1'b1, 1'b0, lane0(32'd4));
    n_checks++;
    if (bus.valid_out !== 1'b1 || bus.vector_out[0] !== 32'd4 || bus.count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL abort_drop_pass got valid=%b lane0=%0d c=%0d, want 1 4 1",
               bus.valid_out, bus.vector_out[0], bus.count_out);
    end
    step(1'b1, 1'b1, 1'b1, lane0(32'd9));
    n_checks++;
    if (bus.vector_out[0] !== 32'd9 || bus.count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL abort_drop got lane0=%0d c=%0d, want 9 1", bus.vector_out[0], bus.count_out);
    end
    drain("abort");
  endtask

  task automatic test_bubbles();
    step(1'b1, 1'b1, 1'b0, lane0(32'd20));
    step(1'b1, 1'b0, 1'b1, lane0(32'd555));
    step(1'b1, 1'b0, 1'b0, lane0(32'd777));
    step(1'b1, 1'b1, 1'b0, lane0(32'd30));
    step(1'b1, 1'b0, 1'b1, lane0(32'd1));
    step(1'b1, 1'b1, 1'b1, lane0(32'd5));
    n_checks++;
    if (bus.vector_out[0] !== 32'd55 || bus.count_out !== 4'd3 || bus.eof_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bubbles got lane0=%0d c=%0d e=%b, want 55 3 1",
               bus.vector_out[0], bus.count_out, bus.eof_out);
    end
    drain("bubbles");
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, lane0(32'd1));
    step(1'b1, 1'b1, 1'b1, lane0(32'd1));
    n_checks++;
    if (bus.vector_out[0] !== 32'd21 || bus.count_out !== 4'(CMAX)) begin
      n_fail++;
      $display("FAIL saturate got lane0=%0d c=%0d, want 21 %0d", bus.vector_out[0], bus.count_out, CMAX);
    end
    drain("saturate");
  endtask

  task automatic test_random();
    vec_t d;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) d[i] = $urandom;
      step($urandom_range(99) < 85, $urandom_range(99) < 70, $urandom_range(99) < 25, d);
    end
    step(1'b1, 1'b1, 1'b1, '0);
    drain("random");
  endtask

  initial begin
    bus.acc_en = 1'b0; bus.valid_in = 1'b0; bus.eof_in = 1'b0; bus.vector_in = '0;
    m_acc = '0; m_cnt = 0;
    last_v = '0; last_c = '0; last_e = 1'b0;
    test_reset();
    test_pass_through();
    test_frame_sum();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_bubbles();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_accumulate_unit.md
VECTOR_ACCUMULATE_UNIT -- requirements
Module: vector_accumulate_unit

Interface
REQ-001 Parameter N, default 8: number of vector lanes, SHALL match the upstream reduce stage.
REQ-002 Parameter DATA_WIDTH, default 32: bits per lane.
REQ-003 Parameter CNT_WIDTH, default 16: width of the sample counter.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port acc_en, input, 1: 1 = accumulate mode, 0 = pass-through mode.
REQ-007 Port valid_in, input, 1: vector_in and eof_in are valid this cycle.
REQ-008 Port eof_in, input, 1: last vector of the current frame; meaningful only when valid_in=1.
REQ-009 Port vector_in, input, N x DATA_WIDTH: reduced vector from the upstream reduce stage.
REQ-010 Port valid_out, output, 1: vector_out, eof_out and count_out are valid this cycle.
REQ-011 Port eof_out, output, 1: the output closes a frame.
REQ-012 Port vector_out, output, N x DATA_WIDTH: pass-through or accumulated vector.
REQ-013 Port count_out, output, CNT_WIDTH: number of input vectors summed into vector_out.

Function
REQ-014 The FSM SHALL have two states. IDLE means the accumulator is empty. ACCUM means the accumulator holds at least one sample.
REQ-015 Pass-through (acc_en=0): on valid_in, the block SHALL register vector_in to vector_out with valid_out=1, eof_out=eof_in and count_out=1. Latency is exactly 1 cycle.
REQ-016 In pass-through mode, the accumulator and FSM SHALL remain in IDLE, with acc cleared and cnt=0.
REQ-017 Accumulate, valid_in=1, eof_in=0: acc[i] <= acc[i]+vector_in[i] per lane; cnt <= cnt+1; state -> ACCUM; valid_out=0.
REQ-018 Accumulate, valid_in=1, eof_in=1: on the next cycle the block SHALL present vector_out[i]=acc[i]+vector_in[i], count_out=cnt+1, valid_out=1 and eof_out=1.
REQ-019 In the same edge as REQ-018, acc SHALL clear to 0, cnt to 0, and the state to IDLE.
REQ-020 An eof_in on the first sample of a frame (state IDLE) SHALL produce an output equal to vector_in with count_out=1.
REQ-021 Lane addition SHALL be modulo 2^DATA_WIDTH (wrap, no saturation, no carry out). Lanes are independent.
REQ-022 cnt SHALL saturate at 2^CNT_WIDTH-1, while accumulation continues.
REQ-023 When valid_in=0, eof_in SHALL be ignored, state and acc SHALL hold, and valid_out=0.
REQ-024 valid_out SHALL be a single-cycle pulse per emitted output. There is no backpressure: downstream always accepts.
REQ-025 acc_en SHALL be sampled every cycle. If acc_en falls while in ACCUM, the partial acc and cnt SHALL be discarded (cleared, IDLE) on that edge.
REQ-026 In the REQ-025 case, any simultaneous valid_in SHALL be handled as pass-through.
REQ-027 When valid_out=0, vector_out, eof_out and count_out SHALL hold their last values.
REQ-028 Maximum throughput SHALL be one vector per cycle. A new frame's first sample is accepted in the cycle immediately after an eof sample.

Reset
REQ-029 While rst_n=0, the block SHALL hold: valid_out=0, eof_out=0, vector_out all lanes 0, count_out=0, acc=0, cnt=0, state IDLE.
REQ-030 Reset asserted mid-frame SHALL discard the partial accumulation, with no output emitted for that frame.
REQ-031 The first valid_in is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 Pass-through: acc_en=0, N=8, vector_in lane0=5 with others 0, valid_in=1. Required response next cycle: valid_out=1, vector_out lane0=5, count_out=1, eof_out=eof_in.
REQ-033 Frame sum: acc_en=1, four vectors of lane0=1,2,3,4, eof on the 4th. Required response: exactly one valid_out pulse, 1 cycle after the 4th input, with lane0=10, count_out=4, eof_out=1.
REQ-034 Back-to-back frames: eof vector lane0=7, then the next cycle lane0=3 with eof. Required response: outputs on consecutive cycles, lane0=7 with count 1, then lane0=3 with count 1.
REQ-035 Wrap: DATA_WIDTH=32, inputs 0xFFFFFFFF then 2 with eof. Required response: lane0=0x00000001, count_out=2.
REQ-036 Abort: three valid vectors, then rst_n pulsed low (or acc_en dropped), then one eof vector lane0=9. Required response: output lane0=9, count_out=1; no stale data.
REQ-037 Bubbles: valid_in gaps between samples of a frame, including eof_in=1 with valid_in=0. Required response: gaps ignored and the sum is unaffected.
